// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions and the fetch FSM state encoding.
package cpu_pkg;
   localparam int OPCODE_MSB  = 15;
   localparam int OPCODE_LSB  = 11;
   localparam int RDST_MSB    = 10;
   localparam int RDST_LSB    = 8;
   localparam int RSRC1_MSB   = 7;
   localparam int RSRC1_LSB   = 5;
   localparam int RSRC2_MSB   = 4;
   localparam int RSRC2_LSB   = 2;
   localparam int HAS_IMM_BIT = 0;

   typedef enum logic {
      S_INSTR = 1'b0,
      S_IMM   = 1'b1
   } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, pipeline control from decode/execute, and IF/ID outputs.
interface fetch_stage_if #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 3,
   parameter int PC_WIDTH      = 16
);
   logic [PC_WIDTH-1:0]      imem_addr;
   logic [DATA_WIDTH-1:0]    imem_data;
   logic                     stall;
   logic                     flush;
   logic [PC_WIDTH-1:0]      branch_target;
   logic                     ifid_valid;
   logic [DATA_WIDTH-1:0]    ifid_instr;
   logic [DATA_WIDTH-1:0]    ifid_imm;
   logic [PC_WIDTH-1:0]      ifid_pc_next;
   logic [ADDRESS_WIDTH-1:0] read_address1;
   logic [ADDRESS_WIDTH-1:0] read_address2;

   modport master (
      output imem_addr, ifid_valid, ifid_instr, ifid_imm, ifid_pc_next,
             read_address1, read_address2,
      input  imem_data, stall, flush, branch_target
   );

   modport slave (
      input  imem_addr, ifid_valid, ifid_instr, ifid_imm, ifid_pc_next,
             read_address1, read_address2,
      output imem_data, stall, flush, branch_target
   );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: clear (flush) beats enable, enable is the inverse of decode stall.
module if_id_register #(
   parameter int DATA_WIDTH = 16,
   parameter int PC_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic                  valid_d,
   input  logic [DATA_WIDTH-1:0] instr_d,
   input  logic [DATA_WIDTH-1:0] imm_d,
   input  logic [PC_WIDTH-1:0]   pc_next_d,
   output logic                  valid_q,
   output logic [DATA_WIDTH-1:0] instr_q,
   output logic [DATA_WIDTH-1:0] imm_q,
   output logic [PC_WIDTH-1:0]   pc_next_q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         instr_q   <= '0;
         imm_q     <= '0;
         pc_next_q <= '0;
      end else if (clr) begin
         valid_q   <= 1'b0;
         instr_q   <= '0;
         imm_q     <= '0;
         pc_next_q <= '0;
      end else if (en) begin
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         imm_q     <= imm_d;
         pc_next_q <= pc_next_d;
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, assembles 1- or 2-word instructions and loads the IF/ID register.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int                  DATA_WIDTH    = 16,
   parameter int                  ADDRESS_WIDTH = 3,
   parameter int                  PC_WIDTH      = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);
   logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc;
   fetch_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;

   logic                  ld_valid;
   logic [DATA_WIDTH-1:0] ld_instr;
   logic [DATA_WIDTH-1:0] ld_imm;
   logic [PC_WIDTH-1:0]   ld_pc_next;

   // Natural PC_WIDTH overflow gives the required wrap from all-ones to zero.
   assign pc_inc        = pc_q + PC_WIDTH'(1);
   assign bus.imem_addr = pc_q;

   always_comb begin
      pc_d         = pc_q;
      state_d      = state_q;
      hold_instr_d = hold_instr_q;
      ld_valid     = 1'b0;
      ld_instr     = '0;
      ld_imm       = '0;
      ld_pc_next   = '0;
      if (bus.flush) begin
         pc_d    = bus.branch_target;
         state_d = S_INSTR;
      end else if (!bus.stall) begin
         pc_d = pc_inc;
         case (state_q)
            S_INSTR: begin
               if (bus.imem_data[HAS_IMM_BIT]) begin
                  // First half of a 2-word instruction: park it, emit a bubble.
                  hold_instr_d = bus.imem_data;
                  state_d      = S_IMM;
               end else begin
                  ld_valid   = 1'b1;
                  ld_instr   = bus.imem_data;
                  ld_pc_next = pc_inc;
               end
            end
            S_IMM: begin
               ld_valid   = 1'b1;
               ld_instr   = hold_instr_q;
               ld_imm     = bus.imem_data;
               ld_pc_next = pc_inc;
               state_d    = S_INSTR;
            end
            default: state_d = S_INSTR;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         state_q      <= S_INSTR;
         hold_instr_q <= '0;
      end else begin
         pc_q         <= pc_d;
         state_q      <= state_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   if_id_register #(
      .DATA_WIDTH(DATA_WIDTH),
      .PC_WIDTH  (PC_WIDTH)
   ) u_if_id (
      .clk      (clk),
      .rst      (rst),
      .en       (~bus.stall),
      .clr      (bus.flush),
      .valid_d  (ld_valid),
      .instr_d  (ld_instr),
      .imm_d    (ld_imm),
      .pc_next_d(ld_pc_next),
      .valid_q  (bus.ifid_valid),
      .instr_q  (bus.ifid_instr),
      .imm_q    (bus.ifid_imm),
      .pc_next_q(bus.ifid_pc_next)
   );

   assign bus.read_address1 = bus.ifid_instr[RSRC1_MSB:RSRC1_LSB];
   assign bus.read_address2 = bus.ifid_instr[RSRC2_MSB:RSRC2_LSB];
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a word-queue reference model.
module tb_fetch_stage;
   logic clk;
   logic rst;
   bit [15:0] mem [65536];

   int total = 0;
   int bad   = 0;

   fetch_stage_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(3), .PC_WIDTH(16)) bif ();

   fetch_stage #(
      .DATA_WIDTH   (16),
      .ADDRESS_WIDTH(3),
      .PC_WIDTH     (16),
      .RESET_PC     (16'h0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif.master)
   );

   assign bif.imem_data = mem[bif.imem_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: collect fetched words until they form a complete instruction.
   logic        m_live = 1'b0;
   logic [15:0] m_pc;
   logic [15:0] m_q [$];
   logic        m_valid;
   logic [15:0] m_instr, m_imm, m_pcn;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_live  = 1'b1;
         m_pc    = 16'h0000;
         m_q.delete();
         m_valid = 1'b0;
      end else if (bif.flush) begin
         m_q.delete();
         m_pc    = bif.branch_target;
         m_valid = 1'b0;
      end else if (!bif.stall) begin
         m_q.push_back(mem[m_pc]);
         m_pc = m_pc + 16'd1;
         if (m_q[0][0] == 1'b0 || m_q.size() == 2) begin
            m_valid = 1'b1;
            m_instr = m_q[0];
            m_imm   = (m_q.size() == 2) ? m_q[1] : 16'h0000;
            m_pcn   = m_pc;
            m_q.delete();
         end else begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live && !rst) begin
         chk("m_addr", 32'(bif.imem_addr), 32'(m_pc));
         chk("m_valid", 32'(bif.ifid_valid), 32'(m_valid));
         if (m_valid) begin
            chk("m_instr", 32'(bif.ifid_instr), 32'(m_instr));
            chk("m_imm", 32'(bif.ifid_imm), 32'(m_imm));
            chk("m_pcnext", 32'(bif.ifid_pc_next), 32'(m_pcn));
            chk("m_ra1", 32'(bif.read_address1), 32'(m_instr[7:5]));
            chk("m_ra2", 32'(bif.read_address2), 32'(m_instr[4:2]));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_out(string name, logic v, logic [15:0] ins, logic [15:0] imm,
                          logic [15:0] pcn, logic [15:0] addr);
      chk({name, "_valid"}, 32'(bif.ifid_valid), 32'(v));
      chk({name, "_instr"}, 32'(bif.ifid_instr), 32'(ins));
      chk({name, "_imm"}, 32'(bif.ifid_imm), 32'(imm));
      chk({name, "_pcnext"}, 32'(bif.ifid_pc_next), 32'(pcn));
      chk({name, "_addr"}, 32'(bif.imem_addr), 32'(addr));
   endtask

   initial begin
      for (int i = 0; i < 80; i++) mem[i] = 16'(i * 16'h0111) ^ 16'(i % 3 == 0);
      mem[16'h0000] = 16'h1234;
      mem[16'h0001] = 16'h0102;
      mem[16'h0002] = 16'h0304;
      mem[16'h0003] = 16'h0506;
      mem[16'h0004] = 16'h2A01;
      mem[16'h0005] = 16'hBEEF;
      mem[16'h0010] = 16'h1010;
      mem[16'h0040] = 16'h4040;
      mem[16'hFFFF] = 16'h3001;

      rst = 1'b0;
      bif.stall = 1'b0;
      bif.flush = 1'b0;
      bif.branch_target = 16'h0000;

      // 1: asynchronous reset takes effect between edges
      #2 rst = 1'b1;
      #1 chk_out("rst_async", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      #9 rst = 1'b0;
      tick();
      chk_out("first", 1'b1, 16'h1234, 16'h0000, 16'h0001, 16'h0001);
      chk("first_ra1", 32'(bif.read_address1), 32'd1);
      chk("first_ra2", 32'(bif.read_address2), 32'd5);
      tick();
      chk_out("second", 1'b1, 16'h0102, 16'h0000, 16'h0002, 16'h0002);
      tick();
      chk_out("third", 1'b1, 16'h0304, 16'h0000, 16'h0003, 16'h0003);

      // 3: stall for three edges freezes everything
      bif.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("stall", 1'b1, 16'h0304, 16'h0000, 16'h0003, 16'h0003);
      end
      bif.stall = 1'b0;
      tick();
      chk_out("after_stall", 1'b1, 16'h0506, 16'h0000, 16'h0004, 16'h0004);

      // 2: two-word instruction produces one bubble
      tick();
      chk("imm_bubble_valid", 32'(bif.ifid_valid), 32'd0);
      chk("imm_bubble_addr", 32'(bif.imem_addr), 32'h5);
      tick();
      chk_out("imm_pair", 1'b1, 16'h2A01, 16'hBEEF, 16'h0006, 16'h0006);

      // 4: flush while half-assembled discards the pending word
      bif.flush = 1'b1; bif.branch_target = 16'h0004;
      tick();
      chk_out("redir4", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0004);
      bif.flush = 1'b0;
      tick();
      chk("simm_valid", 32'(bif.ifid_valid), 32'd0);
      bif.flush = 1'b1; bif.branch_target = 16'h0040;
      tick();
      chk_out("flush_simm", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0040);
      bif.flush = 1'b0;
      tick();
      chk_out("after_flush", 1'b1, 16'h4040, 16'h0000, 16'h0041, 16'h0041);

      // 5: flush has priority over stall
      bif.stall = 1'b1; bif.flush = 1'b1; bif.branch_target = 16'h0010;
      tick();
      chk_out("flush_stall", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0010);
      bif.stall = 1'b0; bif.flush = 1'b0;
      tick();
      chk_out("after_fs", 1'b1, 16'h1010, 16'h0000, 16'h0011, 16'h0011);

      // 6: immediate straddles the PC wrap
      mem[16'h0000] = 16'h00AA;
      bif.flush = 1'b1; bif.branch_target = 16'hFFFF;
      tick();
      chk("wrap_addr", 32'(bif.imem_addr), 32'hFFFF);
      bif.flush = 1'b0;
      tick();
      chk("wrap_bubble", 32'(bif.ifid_valid), 32'd0);
      chk("wrap_addr0", 32'(bif.imem_addr), 32'h0000);
      tick();
      chk_out("wrap_pair", 1'b1, 16'h3001, 16'h00AA, 16'h0001, 16'h0001);

      // reset in the middle of a two-word instruction abandons it
      bif.flush = 1'b1; bif.branch_target = 16'h0004;
      tick();
      bif.flush = 1'b0;
      tick();
      chk("pre_rst_bubble", 32'(bif.ifid_valid), 32'd0);
      #2 rst = 1'b1;
      #1 chk_out("rst_mid", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      #2 rst = 1'b0;
      tick();
      chk("rst_mid_hold", 32'(bif.ifid_valid), 32'd0);
      tick();
      chk_out("rst_mid_after", 1'b1, 16'h00AA, 16'h0000, 16'h0001, 16'h0001);

      // mixed stall/flush traffic checked by the reference model
      for (int i = 0; i < 60; i++) begin
         bif.stall = ($urandom_range(0, 3) == 0);
         bif.flush = ($urandom_range(0, 7) == 0);
         bif.branch_target = 16'($urandom_range(0, 20));
         tick();
      end
      bif.stall = 1'b0;
      bif.flush = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
